// File: rtl/pic_int_sequencer.sv
// pic_int_sequencer: interrupt sequencer for the PIC core.
//  - Synchronizes the raw request lines and latches rising edges into IRR.
//  - Masks with IMR and resolves fixed priority (IR0 highest) against the
//    lowest in-service level (fully nested mode).
//  - Raises int_out and runs the two-pulse INTA cycle. The 1st INTA latches
//    the winning level and sets its ISR bit. The 2nd INTA returns the vector.
//  - Non-specific and specific EOI clear ISR bits.
// Optional build macro: PIC_AUTO_EOI_EN. When it is defined, the 2nd INTA of a
// real (non-spurious) acknowledge clears the ISR bit it set.
module pic_int_sequencer #(
  parameter int NUM_IR      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IR-1:0] ir_req,
  input  logic [NUM_IR-1:0] imr,
  input  logic [4:0]        vec_base,
  input  logic              inta,
  input  logic              eoi,
  input  logic              seoi,
  input  logic [2:0]        seoi_level,
  output logic              int_out,
  output logic [7:0]        vector,
  output logic              vector_valid,
  output logic [NUM_IR-1:0] irr,
  output logic [NUM_IR-1:0] isr,
  output logic [2:0]        ack_level
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_ACK1 = 2'd2
  } state_t;

  // Index of the lowest set bit, or 8 when no bit is set.
  function automatic logic [3:0] lowest_idx(input logic [7:0] v);
    logic [3:0] r;
    r = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        r = 4'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // 3-to-8 one-hot decoder.
  function automatic logic [7:0] decode3(input logic [2:0] lvl);
    return 8'h01 << lvl;
  endfunction

  state_t     state_r;
  logic [7:0] sync_r [SYNC_STAGES];
  logic [7:0] prev_r;
`ifdef PIC_AUTO_EOI_EN
  logic       spur_r;
  logic [7:0] auto_clr_s;
`endif

  logic [7:0] edge_s;
  logic [7:0] cand_s;
  logic [3:0] highest_s;
  logic [3:0] ceiling_s;
  logic       pending_s;
  logic       ack_take_s;
  logic [7:0] ack_set_s;
  logic [7:0] eoi_clr_s;

  // Synchronizer chain plus the previous-value flop used to find rising edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= 8'h00;
      end
      prev_r <= 8'h00;
    end else begin
      sync_r[0] <= ir_req;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  // Priority resolution, acknowledge set/clear masks and EOI clear masks.
  always_comb begin
    edge_s     = sync_r[SYNC_STAGES-1] & ~prev_r;
    cand_s     = irr & ~imr;
    highest_s  = lowest_idx(cand_s);
    ceiling_s  = lowest_idx(isr);
    pending_s  = (cand_s != 8'h00) && (highest_s < ceiling_s);
    ack_take_s = (state_r == ST_PEND) && inta && pending_s;
    if (ack_take_s) begin
      ack_set_s = decode3(highest_s[2:0]);
    end else begin
      ack_set_s = 8'h00;
    end
    eoi_clr_s = 8'h00;
    if (eoi && (isr != 8'h00)) begin
      eoi_clr_s = eoi_clr_s | decode3(ceiling_s[2:0]);
    end else begin
      eoi_clr_s = eoi_clr_s;
    end
    if (seoi) begin
      eoi_clr_s = eoi_clr_s | decode3(seoi_level);
    end else begin
      eoi_clr_s = eoi_clr_s;
    end
`ifdef PIC_AUTO_EOI_EN
    if ((state_r == ST_ACK1) && inta && !spur_r) begin
      auto_clr_s = decode3(ack_level);
    end else begin
      auto_clr_s = 8'h00;
    end
`endif
  end

  // IRR and ISR update: clears before sets, so a new edge or an acknowledge
  // always wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irr <= 8'h00;
      isr <= 8'h00;
    end else begin
      irr <= (irr & ~ack_set_s) | edge_s;
`ifdef PIC_AUTO_EOI_EN
      isr <= (isr & ~eoi_clr_s & ~auto_clr_s) | ack_set_s;
`else
      isr <= (isr & ~eoi_clr_s) | ack_set_s;
`endif
    end
  end

  // INTA sequencing FSM with registered int_out, vector and ack_level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      int_out      <= 1'b0;
      vector       <= 8'h00;
      vector_valid <= 1'b0;
      ack_level    <= 3'd0;
`ifdef PIC_AUTO_EOI_EN
      spur_r       <= 1'b0;
`endif
    end else begin
      vector_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pending_s) begin
            state_r <= ST_PEND;
            int_out <= 1'b1;
          end else begin
            int_out <= 1'b0;
          end
        end
        ST_PEND: begin
          if (inta) begin
            state_r <= ST_ACK1;
            int_out <= 1'b0;
            if (pending_s) begin
              ack_level <= highest_s[2:0];
            end else begin
              ack_level <= 3'd7;
            end
`ifdef PIC_AUTO_EOI_EN
            spur_r <= !pending_s;
`endif
          end else if (!pending_s) begin
            state_r <= ST_IDLE;
            int_out <= 1'b0;
          end else begin
            int_out <= 1'b1;
          end
        end
        ST_ACK1: begin
          int_out <= 1'b0;
          if (inta) begin
            state_r      <= ST_IDLE;
            vector       <= {vec_base, ack_level};
            vector_valid <= 1'b1;
          end else begin
            state_r <= ST_ACK1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          int_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pic_int_sequencer.sv
// Self-checking bench for pic_int_sequencer: directed scenarios followed by
// randomized traffic compared every cycle against a behavioural model.
module tb_pic_int_sequencer;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ir_req = 8'h00;
  logic [7:0] imr = 8'h00;
  logic [4:0] vec_base = 5'h08;
  logic       inta = 1'b0;
  logic       eoi = 1'b0;
  logic       seoi = 1'b0;
  logic [2:0] seoi_level = 3'd0;
  logic       int_out;
  logic [7:0] vector;
  logic       vector_valid;
  logic [7:0] irr;
  logic [7:0] isr;
  logic [2:0] ack_level;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state.
  logic [7:0] m_irr, m_isr, m_vec;
  logic       m_int, m_vv, m_spur;
  logic [2:0] m_ack;
  int         m_phase;            // 0 idle, 1 request raised, 2 between INTA pulses
  logic [7:0] hist [0:SYNC];      // ir_req samples at past edges, [0] most recent

  pic_int_sequencer #(.NUM_IR(8), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .ir_req(ir_req), .imr(imr), .vec_base(vec_base),
    .inta(inta), .eoi(eoi), .seoi(seoi), .seoi_level(seoi_level),
    .int_out(int_out), .vector(vector), .vector_valid(vector_valid),
    .irr(irr), .isr(isr), .ack_level(ack_level)
  );

  always #5 clk = ~clk;

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 8;
  endfunction

  task automatic model_reset();
    m_irr = 8'h00; m_isr = 8'h00; m_vec = 8'h00;
    m_int = 1'b0; m_vv = 1'b0; m_spur = 1'b0; m_ack = 3'd0; m_phase = 0;
    for (int k = 0; k <= SYNC; k++) hist[k] = 8'h00;
  endtask

  // Advance one clock: evaluate the model from current inputs, then commit
  // it 1 time unit after the rising edge.
  task automatic step();
    logic [7:0] new_edges, clr, set_mask, auto_clr;
    int hi, ce, n_phase;
    bit pend;
    logic n_int, n_vv, n_spur;
    logic [2:0] n_ack;
    logic [7:0] n_vec;
    new_edges = hist[SYNC-1] & ~hist[SYNC];
    hi = lowest(m_irr & ~imr);
    ce = lowest(m_isr);
    pend = (hi < 8) && (hi < ce);
    clr = 8'h00;
    if (eoi && ce < 8) clr[ce] = 1'b1;
    if (seoi) clr[seoi_level] = 1'b1;
    set_mask = 8'h00;
    if (m_phase == 1 && inta && pend) set_mask[hi] = 1'b1;
    auto_clr = 8'h00;
`ifdef PIC_AUTO_EOI_EN
    if (m_phase == 2 && inta && !m_spur) auto_clr[m_ack] = 1'b1;
`endif
    n_phase = m_phase; n_int = m_int; n_vv = 1'b0; n_vec = m_vec;
    n_ack = m_ack; n_spur = m_spur;
    if (m_phase == 0) begin
      n_int = pend;
      if (pend) n_phase = 1;
    end else if (m_phase == 1) begin
      if (inta) begin
        n_phase = 2; n_int = 1'b0; n_spur = !pend;
        n_ack = pend ? 3'(hi) : 3'd7;
      end else if (!pend) begin
        n_phase = 0; n_int = 1'b0;
      end
    end else begin
      n_int = 1'b0;
      if (inta) begin
        n_phase = 0; n_vv = 1'b1; n_vec = {vec_base, m_ack};
      end
    end
    @(posedge clk);
    #1;
    m_irr = (m_irr & ~set_mask) | new_edges;
    m_isr = (m_isr & ~clr & ~auto_clr) | set_mask;
    m_phase = n_phase; m_int = n_int; m_vv = n_vv; m_vec = n_vec;
    m_ack = n_ack; m_spur = n_spur;
    for (int k = SYNC; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = ir_req;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if ({int_out, vector, vector_valid, irr, isr, ack_level} !== 30'd0) begin
      n_bad++;
      $display("FAIL reset_state: got int=%b vec=%h vv=%b irr=%h isr=%h lvl=%0d, want all 0",
               int_out, vector, vector_valid, irr, isr, ack_level);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_irr_latch();
    imr = 8'h00; vec_base = 5'h08; ir_req[3] = 1'b1;
    step(); step();
    n_cmp++;
    if (irr !== 8'h00) begin n_bad++; $display("FAIL irr_sync_delay: got %h want 00", irr); end
    step();
    n_cmp++;
    if (irr !== 8'h08 || int_out !== 1'b0) begin
      n_bad++; $display("FAIL irr_latch: got irr=%h int=%b want 08/0", irr, int_out);
    end
    step();
    n_cmp++;
    if (int_out !== 1'b1) begin n_bad++; $display("FAIL int_raise: got %b want 1", int_out); end
  endtask

  task automatic test_ack_cycle();
    logic [7:0] exp_isr;
    inta = 1'b1; step(); inta = 1'b0;
    n_cmp++;
    if (ack_level !== 3'd3 || isr !== 8'h08 || irr !== 8'h00 || int_out !== 1'b0) begin
      n_bad++; $display("FAIL first_inta: got lvl=%0d isr=%h irr=%h int=%b want 3/08/00/0",
                        ack_level, isr, irr, int_out);
    end
    repeat (3) step();
    n_cmp++;
    if (vector_valid !== 1'b0) begin n_bad++; $display("FAIL vv_early: got %b want 0", vector_valid); end
    inta = 1'b1; step(); inta = 1'b0;
`ifdef PIC_AUTO_EOI_EN
    exp_isr = 8'h00;
`else
    exp_isr = 8'h08;
`endif
    n_cmp++;
    if (vector_valid !== 1'b1 || vector !== 8'h43 || isr !== exp_isr) begin
      n_bad++; $display("FAIL second_inta: got vv=%b vec=%h isr=%h want 1/43/%h",
                        vector_valid, vector, isr, exp_isr);
    end
    step();
    n_cmp++;
    if (vector_valid !== 1'b0) begin n_bad++; $display("FAIL vv_one_cycle: got %b want 0", vector_valid); end
    ir_req[3] = 1'b0;
  endtask

  task automatic test_nesting();
    int waited;
    ir_req = 8'h20;
    repeat (6) begin
      step();
      n_cmp++;
      if (int_out !== m_int) begin n_bad++; $display("FAIL nest_block: got int=%b want %b", int_out, m_int); end
    end
`ifndef PIC_AUTO_EOI_EN
    n_cmp++;
    if (int_out !== 1'b0 || irr !== 8'h20) begin
      n_bad++; $display("FAIL nest_lower_blocked: got int=%b irr=%h want 0/20", int_out, irr);
    end
`endif
    ir_req[1] = 1'b1;
    waited = 0;
    do begin step(); waited++; end while (int_out !== 1'b1 && waited < 12);
    n_cmp++;
    if (int_out !== 1'b1) begin n_bad++; $display("FAIL nest_ir1_timeout: got int=%b want 1", int_out); end
    inta = 1'b1; step(); inta = 1'b0;
    repeat (3) step();
    inta = 1'b1; step(); inta = 1'b0;
    n_cmp++;
    if (vector_valid !== m_vv || vector !== m_vec || isr !== m_isr) begin
      n_bad++; $display("FAIL nest_ack: got vv=%b vec=%h isr=%h want %b/%h/%h",
                        vector_valid, vector, isr, m_vv, m_vec, m_isr);
    end
`ifndef PIC_AUTO_EOI_EN
    n_cmp++;
    if (vector !== 8'h41 || isr !== 8'h0A) begin
      n_bad++; $display("FAIL nest_ir1_vector: got vec=%h isr=%h want 41/0A", vector, isr);
    end
`endif
    eoi = 1'b1; step(); eoi = 1'b0;
    n_cmp++;
    if (isr !== m_isr) begin n_bad++; $display("FAIL eoi_clear: got isr=%h want %h", isr, m_isr); end
`ifndef PIC_AUTO_EOI_EN
    n_cmp++;
    if (isr !== 8'h08) begin n_bad++; $display("FAIL eoi_lowest: got isr=%h want 08", isr); end
`endif
    seoi = 1'b1; seoi_level = 3'd3; step(); seoi = 1'b0;
    n_cmp++;
    if (isr !== 8'h00) begin n_bad++; $display("FAIL seoi_clear: got isr=%h want 00", isr); end
    waited = 0;
    while (m_phase != 1 && waited < 12) begin step(); waited++; end
    step();
    n_cmp++;
    if (int_out !== m_int) begin n_bad++; $display("FAIL ir5_release: got int=%b want %b", int_out, m_int); end
    if (m_phase == 1) begin
      inta = 1'b1; step(); step(); step(); inta = 1'b0;
      n_cmp++;
      if (vector_valid !== m_vv || vector !== m_vec) begin
        n_bad++; $display("FAIL ir5_vector: got vv=%b vec=%h want %b/%h",
                          vector_valid, vector, m_vv, m_vec);
      end
    end
    eoi = 1'b1; seoi = 1'b1; seoi_level = 3'd1; step(); eoi = 1'b0; seoi = 1'b0;
    ir_req = 8'h00;
    repeat (4) step();
  endtask

  task automatic test_spurious();
    int waited;
    logic [7:0] isr_before;
    ir_req[6] = 1'b1;
    waited = 0;
    do begin step(); waited++; end while (int_out !== 1'b1 && waited < 12);
    n_cmp++;
    if (int_out !== 1'b1) begin n_bad++; $display("FAIL spur_int_timeout: got %b want 1", int_out); end
    isr_before = m_isr;
    imr = 8'h40; inta = 1'b1; step(); inta = 1'b0;
    n_cmp++;
    if (ack_level !== 3'd7 || irr[6] !== 1'b1 || isr !== isr_before) begin
      n_bad++; $display("FAIL spur_first: got lvl=%0d irr=%h isr=%h want 7/bit6/%h",
                        ack_level, irr, isr, isr_before);
    end
    step();
    inta = 1'b1; step(); inta = 1'b0;
    n_cmp++;
    if (vector_valid !== 1'b1 || vector !== 8'h47 || isr !== isr_before) begin
      n_bad++; $display("FAIL spur_vector: got vv=%b vec=%h isr=%h want 1/47/%h",
                        vector_valid, vector, isr, isr_before);
    end
    imr = 8'h00;
  endtask

  task automatic test_reset_mid_ack();
    int waited;
    waited = 0;
    do begin step(); waited++; end while (int_out !== 1'b1 && waited < 12);
    n_cmp++;
    if (int_out !== 1'b1) begin n_bad++; $display("FAIL rst_int_timeout: got %b want 1", int_out); end
    inta = 1'b1; step(); inta = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({int_out, vector, vector_valid, irr, isr, ack_level} !== 30'd0) begin
      n_bad++; $display("FAIL mid_reset: got int=%b vec=%h vv=%b irr=%h isr=%h lvl=%0d want all 0",
                        int_out, vector, vector_valid, irr, isr, ack_level);
    end
    #10 rst = 1'b0;
    model_reset();
    inta = 1'b1; step(); inta = 1'b0;
    n_cmp++;
    if (vector_valid !== 1'b0 || int_out !== 1'b0) begin
      n_bad++; $display("FAIL post_reset_inta: got vv=%b int=%b want 0/0", vector_valid, int_out);
    end
    ir_req = 8'h00;
    repeat (6) step();
  endtask

  task automatic test_random();
    logic [7:0] mask;
    for (int cyc = 0; cyc < 800; cyc++) begin
      mask = 8'($urandom) & 8'($urandom) & 8'($urandom);
      ir_req = ir_req ^ mask;
      imr = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h00;
      if (m_phase != 0) inta = ($urandom_range(0, 1) == 1);
      else inta = ($urandom_range(0, 19) == 0);
      eoi = ($urandom_range(0, 9) == 0);
      seoi = ($urandom_range(0, 15) == 0);
      seoi_level = 3'($urandom);
      step();
      n_cmp++;
      if ({int_out, irr, isr, ack_level, vector_valid, (vector_valid ? vector : 8'h00)} !==
          {m_int, m_irr, m_isr, m_ack, m_vv, (m_vv ? m_vec : 8'h00)}) begin
        n_bad++;
        $display("FAIL random_cycle%0d: got int=%b irr=%h isr=%h lvl=%0d vv=%b vec=%h want int=%b irr=%h isr=%h lvl=%0d vv=%b vec=%h",
                 cyc, int_out, irr, isr, ack_level, vector_valid, vector,
                 m_int, m_irr, m_isr, m_ack, m_vv, m_vec);
      end
    end
    inta = 1'b0; eoi = 1'b0; seoi = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_irr_latch();
    test_ack_cycle();
    test_nesting();
    test_spurious();
    test_reset_mid_ack();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
